icmp_rx_echo: RTL and testbench
===============================

# icmp_rx_echo

Parametrised ICMP receive block: parses the ICMP header from the byte stream delivered by the IP receive layer, verifies the ICMP checksum and length, and buffers the echo payload for the transmit side. It raises a reply trigger to the ICMP transmit block only at end of frame, and only for a well-formed echo request. The trigger carries identifier, sequence and payload length, and the payload stays readable from the buffer until the transmitter releases it.

## Interface
- P_PLD_DEPTH, 1024: payload buffer depth in bytes; power of two, 64..65536.
- P_CSUM_EN, 1: 1 = a checksum mismatch suppresses the reply; 0 = the checksum is computed and flagged but ignored.
- P_ADDR_W, $clog2(P_PLD_DEPTH): buffer address width; derived, never overridden.
- i_clk  in  1  sole clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_icmp_data  in  8  ICMP byte, first byte = TYPE.
- i_icmp_len  in  16  total ICMP length in bytes; sampled on the first byte.
- i_icmp_last  in  1  marks the final byte.
- i_icmp_valid  in  1  byte qualifier; no backpressure.
- i_pld_lock  in  1  transmitter is reading the buffer; hold the buffer contents.
- i_pld_rd_addr  in  P_ADDR_W  buffer read address.
- o_pld_rd_data  out  8  buffer read data, 1-cycle latency.
- o_trig_reply  out  1  one-cycle pulse for an accepted echo request.
- o_trig_seq  out  16  sequence number of the last accepted request.
- o_trig_id  out  16  identifier of the last accepted request.
- o_pld_len  out  16  payload byte count of the last accepted request.
- o_err_csum  out  1  one-cycle pulse for a checksum mismatch.
- o_err_len  out  1  one-cycle pulse for a length error, truncation or oversize.
- o_drop  out  1  one-cycle pulse for a valid echo request dropped because of the lock.

## Operation
- Input isolation: the four input signals are registered into one stage and cleared to 0 when i_icmp_valid=0. All parsing runs on the registered stage.
- Byte counter (16 bit): counts registered valid bytes and saturates at 16'hFFFF. It clears when the registered valid goes low, and after last.
- Header capture by offset:
  - 0: TYPE
  - 1: CODE
  - 2-3: checksum (accumulated only)
  - 4-5: ID, big-endian
  - 6-7: SEQ, big-endian
- Captured fields live in shadow registers. They are copied to o_trig_* only when a reply fires.
- Checksum: 16-bit ones-complement sum over every byte. Even offsets are the high byte, odd offsets the low byte. An odd total length pads the low byte with 0x00. End-around carry is folded on every add. The frame passes when the final folded sum = 16'hFFFF.
- Payload: bytes at offset ≥8 are written to the buffer at address offset-8.
  - Writes are blocked while i_pld_lock=1.
  - Writes at offset-8 ≥ P_PLD_DEPTH are discarded. There is no wrap-around; the frame is marked oversize.
- Frame-end evaluation, on the registered last:
  - len_ok: count = sampled i_icmp_len, count ≥ 8, and not oversize.
  - csum_ok: as defined above.
  - is_req: TYPE=8 and CODE=0.
- Outcomes (exactly one reply/drop decision per frame):
  - is_req & len_ok & (csum_ok | !P_CSUM_EN) & !lock_seen → o_trig_reply, o_trig_* update.
  - Same conditions with lock_seen → o_drop, o_trig_* unchanged.
  - !len_ok → o_err_len.
  - !csum_ok → o_err_csum, regardless of TYPE and regardless of P_CSUM_EN.
  - o_err_len and o_err_csum may pulse in the same cycle.
- lock_seen is set if i_pld_lock was high on any payload byte of the frame.
- Truncation: the registered valid falls without a last. The frame aborts, o_err_len pulses once, there is no reply, and the counter and accumulator clear.
- Frames with TYPE≠8 are parsed and checksummed and produce no reply. This is not an error.
- Buffer read is independent of writes. A read and write to the same address in the same cycle returns the old data.

## Timing
- Edge E0 samples i_icmp_last; the registered stage holds it after E0; o_trig_reply, o_drop, o_err_* are high for one cycle after E2.
- o_trig_seq, o_trig_id and o_pld_len change on the same edge as o_trig_reply and hold until the next accepted request.
- Back-to-back frames with zero idle cycles are supported. Evaluation of frame N overlaps the first bytes of frame N+1.
- Reset, including mid-frame: all outputs 0, counter, accumulator, shadow registers and lock_seen cleared. Buffer contents are undefined after reset.

## Structure
- Shared package icmp_pkg:
  - ICMP_TYPE_ECHO_REQ=8, ICMP_TYPE_ECHO_REPLY=0
  - ICMP_HDR_LEN=8
  - Field offsets for TYPE, CODE, CSUM, ID, SEQ
- Sub-module icmp_csum16: byte-serial ones-complement accumulator with inputs clear, byte_valid, odd/even select and final-pad, and outputs the folded sum.
- Payload buffer inferred as a simple dual-port RAM inside the block.

## Test plan
- Echo request with ID 0x1234, SEQ 0x0007, 32-byte payload 0x00..0x1F, correct checksum → o_trig_reply 2 cycles after last, seq=0x0007, id=0x1234, pld_len=32, buffer addr 5 reads 0x05.
- Same frame with the checksum field off by one → o_err_csum pulse, no reply, o_trig_seq keeps its previous value. With P_CSUM_EN=0 → both o_err_csum and o_trig_reply pulse.
- Odd-length request with a 33-byte payload, correct checksum → reply, pld_len=33.
- Payload of P_PLD_DEPTH+1 bytes → o_err_len, no reply, buffer addr 0 still holds the first byte.
- i_pld_lock high during the payload of a valid request → o_drop, buffer unchanged, no reply. TYPE=0 frame → no reply, no error.
- i_icmp_valid drops at byte 5 without last → o_err_len once. Then a back-to-back valid request with zero gap → reply. Then i_rst asserted mid-frame → all outputs 0.

Source files
------------

// File: rtl/icmp_pkg.sv
// Shared ICMP receive definitions: message types, header layout, stage structs.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package icmp_pkg;

  localparam logic [7:0]  ICMP_TYPE_ECHO_REQ   = 8'd8;
  localparam logic [7:0]  ICMP_TYPE_ECHO_REPLY = 8'd0;
  localparam logic [15:0] ICMP_HDR_LEN         = 16'd8;

  // Byte offsets of the header fields from the TYPE byte
  localparam logic [15:0] OFS_TYPE = 16'd0;
  localparam logic [15:0] OFS_CODE = 16'd1;
  localparam logic [15:0] OFS_CSUM = 16'd2;
  localparam logic [15:0] OFS_ID   = 16'd4;
  localparam logic [15:0] OFS_SEQ  = 16'd6;

  // Registered copy of the incoming byte stream
  typedef struct packed {
    logic        vld;
    logic        last;
    logic [7:0]  dat;
    logic [15:0] len;
  } icmp_in_t;

  // Header fields captured while a frame streams in
  typedef struct packed {
    logic [7:0]  typ;
    logic [7:0]  code;
    logic [15:0] id;
    logic [15:0] seq;
  } icmp_hdr_t;

  // Frame-end snapshot handed to the decision stage
  typedef struct packed {
    logic        vld;
    logic        trunc;
    logic        len_ok;
    logic        req;
    logic        lock;
    logic [15:0] id;
    logic [15:0] seq;
    logic [15:0] pld_len;
  } icmp_eval_t;

  function automatic logic is_echo_req(input icmp_hdr_t h);
    return (h.typ == ICMP_TYPE_ECHO_REQ) && (h.code == 8'd0);
  endfunction

endpackage

// File: rtl/icmp_csum16.sv
// Byte-serial 16-bit ones-complement accumulator (even byte = high, odd = low).
// Latency: o_sum includes a byte one cycle after it is presented.
// Backpressure: none; accepts a byte every cycle.
// Ports: i_clear restarts the sum (a byte presented with it is the first byte),
//   i_byte_valid/i_byte the data, i_odd selects the low half of a word,
//   i_final_pad closes an odd-length frame with a 0x00 low byte, o_sum the folded sum.
module icmp_csum16 (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_byte_valid,
  input  logic        i_odd,
  input  logic        i_final_pad,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_sum
);

  logic [15:0] sum_q, sum_d, sum_base;
  logic [7:0]  hi_q, hi_d, hi_base;

  // Add with end-around carry; a single fold always suffices here
  function automatic logic [15:0] fold_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  always_comb begin
    sum_base = i_clear ? 16'd0 : sum_q;
    hi_base  = i_clear ? 8'd0  : hi_q;
    sum_d    = sum_base;
    hi_d     = hi_base;
    if (i_byte_valid) begin
      if (i_odd) begin
        sum_d = fold_add(sum_base, {hi_base, i_byte});
      end else if (i_final_pad) begin
        sum_d = fold_add(sum_base, {i_byte, 8'h00});
      end else begin
        // High byte waits for its low partner
        hi_d = i_byte;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sum_q <= 16'd0;
      hi_q  <= 8'd0;
    end else begin
      sum_q <= sum_d;
      hi_q  <= hi_d;
    end
  end

  assign o_sum = sum_q;

endmodule

// File: rtl/icmp_rx_echo.sv
// ICMP receive: parses header, checks length/checksum, buffers echo payload, triggers reply.
// Latency: reply/drop/error pulses are registered two edges after the edge sampling i_icmp_last.
// Backpressure: none on the byte stream; i_pld_lock freezes the payload buffer instead.
// Ports: i_icmp_* byte stream from IP rx (TYPE first, length sampled on first byte);
//   i_pld_lock/i_pld_rd_addr/o_pld_rd_data transmit-side buffer access (1-cycle read);
//   o_trig_* reply trigger and fields; o_err_csum/o_err_len/o_drop status pulses.
module icmp_rx_echo
  import icmp_pkg::*;
#(
  parameter int P_PLD_DEPTH = 1024,
  parameter bit P_CSUM_EN   = 1'b1,
  parameter int P_ADDR_W    = $clog2(P_PLD_DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [7:0]          i_icmp_data,
  input  logic [15:0]         i_icmp_len,
  input  logic                i_icmp_last,
  input  logic                i_icmp_valid,
  input  logic                i_pld_lock,
  input  logic [P_ADDR_W-1:0] i_pld_rd_addr,
  output logic [7:0]          o_pld_rd_data,
  output logic                o_trig_reply,
  output logic [15:0]         o_trig_seq,
  output logic [15:0]         o_trig_id,
  output logic [15:0]         o_pld_len,
  output logic                o_err_csum,
  output logic                o_err_len,
  output logic                o_drop
);

  icmp_in_t    r_in;
  icmp_hdr_t   hdr_q, hdr_nxt;
  icmp_eval_t  ev_d, ev_q;

  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic [15:0] len_q, len_cur;
  logic [15:0] pld_ofs;
  logic [15:0] csum_sum;
  logic        first, pld_byte, over_byte, pld_we;
  logic        end_frm, trunc;
  logic        lock_q, lock_nxt, ovr_q, ovr_nxt;
  logic        len_ok_d, csum_ok, accept;

  logic [7:0]  pld_mem [P_PLD_DEPTH];

  // Input isolation: nothing downstream sees bytes outside valid
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_in <= '0;
    end else if (i_icmp_valid) begin
      r_in <= '{vld: 1'b1, last: i_icmp_last, dat: i_icmp_data, len: i_icmp_len};
    end else begin
      r_in <= '0;
    end
  end

  // cnt_q is the offset of the byte currently in r_in
  assign first     = r_in.vld && (cnt_q == 16'd0);
  assign pld_byte  = r_in.vld && (cnt_q >= ICMP_HDR_LEN);
  assign pld_ofs   = cnt_q - ICMP_HDR_LEN;
  assign over_byte = pld_byte && ({16'd0, pld_ofs} >= 32'(P_PLD_DEPTH));
  assign pld_we    = pld_byte && !over_byte && !i_pld_lock;
  assign end_frm   = r_in.vld && r_in.last;
  // Valid fell in mid-frame without a last
  assign trunc     = !r_in.vld && (cnt_q != 16'd0);

  assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign cnt_d     = (r_in.vld && !r_in.last) ? cnt_inc : 16'd0;

  // A frame's own first byte carries the length, so bypass the register there
  assign len_cur   = first ? r_in.len : len_q;
  assign lock_nxt  = (!first && lock_q) || (pld_byte && i_pld_lock);
  assign ovr_nxt   = (!first && ovr_q) || over_byte;
  assign len_ok_d  = (cnt_inc == len_cur) && (cnt_inc >= ICMP_HDR_LEN) && !ovr_nxt;

  // Shadow header with the current byte merged in, so a frame ending on
  // the last SEQ byte is evaluated with complete fields
  always_comb begin
    hdr_nxt = first ? '0 : hdr_q;
    if (r_in.vld) begin
      case (cnt_q)
        OFS_TYPE:          hdr_nxt.typ       = r_in.dat;
        OFS_CODE:          hdr_nxt.code      = r_in.dat;
        OFS_ID:            hdr_nxt.id[15:8]  = r_in.dat;
        OFS_ID + 16'd1:    hdr_nxt.id[7:0]   = r_in.dat;
        OFS_SEQ:           hdr_nxt.seq[15:8] = r_in.dat;
        OFS_SEQ + 16'd1:   hdr_nxt.seq[7:0]  = r_in.dat;
        default: ;
      endcase
    end
  end

  always_comb begin
    ev_d       = '0;
    ev_d.trunc = trunc;
    if (end_frm) begin
      ev_d.vld     = 1'b1;
      ev_d.len_ok  = len_ok_d;
      ev_d.req     = is_echo_req(hdr_nxt);
      ev_d.lock    = lock_nxt;
      ev_d.id      = hdr_nxt.id;
      ev_d.seq     = hdr_nxt.seq;
      ev_d.pld_len = cnt_inc - ICMP_HDR_LEN;
    end
  end

  icmp_csum16 u_csum (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (first || trunc),
    .i_byte_valid (r_in.vld),
    .i_odd        (cnt_q[0]),
    .i_final_pad  (end_frm && !cnt_q[0]),
    .i_byte       (r_in.dat),
    .o_sum        (csum_sum)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q  <= 16'd0;
      len_q  <= 16'd0;
      hdr_q  <= '0;
      lock_q <= 1'b0;
      ovr_q  <= 1'b0;
      ev_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      if (first) len_q <= r_in.len;
      hdr_q  <= hdr_nxt;
      lock_q <= (r_in.vld && !r_in.last) ? lock_nxt : 1'b0;
      ovr_q  <= (r_in.vld && !r_in.last) ? ovr_nxt : 1'b0;
      ev_q   <= ev_d;
    end
  end

  // The accumulator still holds the finished frame's sum here; the next
  // frame's first byte only replaces it on this same edge
  assign csum_ok = (csum_sum == 16'hFFFF);
  assign accept  = ev_q.vld && ev_q.req && ev_q.len_ok && (csum_ok || !P_CSUM_EN);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_trig_reply <= 1'b0;
      o_drop       <= 1'b0;
      o_err_len    <= 1'b0;
      o_err_csum   <= 1'b0;
      o_trig_seq   <= 16'd0;
      o_trig_id    <= 16'd0;
      o_pld_len    <= 16'd0;
    end else begin
      o_trig_reply <= accept && !ev_q.lock;
      o_drop       <= accept && ev_q.lock;
      o_err_len    <= (ev_q.vld && !ev_q.len_ok) || ev_q.trunc;
      o_err_csum   <= ev_q.vld && !csum_ok;
      if (accept && !ev_q.lock) begin
        o_trig_seq <= ev_q.seq;
        o_trig_id  <= ev_q.id;
        o_pld_len  <= ev_q.pld_len;
      end
    end
  end

  // Simple dual-port payload buffer; read returns pre-write data on collision
  always_ff @(posedge i_clk) begin
    if (pld_we) pld_mem[pld_ofs[P_ADDR_W-1:0]] <= r_in.dat;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_pld_rd_data <= 8'd0;
    else       o_pld_rd_data <= pld_mem[i_pld_rd_addr];
  end

endmodule

// File: tb/tb_icmp_rx_echo.sv
module tb_icmp_rx_echo;

  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [7:0]    i_icmp_data;
  logic [15:0]   i_icmp_len;
  logic          i_icmp_last;
  logic          i_icmp_valid;
  logic          i_pld_lock;
  logic [AW-1:0] i_pld_rd_addr;

  logic [7:0]  o_pld_rd_data, nc_pld_rd_data;
  logic        o_trig_reply, nc_trig_reply;
  logic [15:0] o_trig_seq, nc_trig_seq;
  logic [15:0] o_trig_id, nc_trig_id;
  logic [15:0] o_pld_len, nc_pld_len;
  logic        o_err_csum, nc_err_csum;
  logic        o_err_len, nc_err_len;
  logic        o_drop, nc_drop;

  int checks = 0;
  int errors = 0;

  // Pulse counters, sampled away from the active edge
  int n_rep = 0, n_drop = 0, n_elen = 0, n_ecs = 0;
  int m_rep = 0, m_ecs = 0;

  logic [7:0] frm[$];

  always #5 i_clk = ~i_clk;

  icmp_rx_echo #(.P_PLD_DEPTH(DEPTH), .P_CSUM_EN(1'b1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_icmp_data(i_icmp_data), .i_icmp_len(i_icmp_len),
    .i_icmp_last(i_icmp_last), .i_icmp_valid(i_icmp_valid), .i_pld_lock(i_pld_lock),
    .i_pld_rd_addr(i_pld_rd_addr), .o_pld_rd_data(o_pld_rd_data), .o_trig_reply(o_trig_reply),
    .o_trig_seq(o_trig_seq), .o_trig_id(o_trig_id), .o_pld_len(o_pld_len),
    .o_err_csum(o_err_csum), .o_err_len(o_err_len), .o_drop(o_drop)
  );

  icmp_rx_echo #(.P_PLD_DEPTH(DEPTH), .P_CSUM_EN(1'b0)) dut_nc (
    .i_clk(i_clk), .i_rst(i_rst), .i_icmp_data(i_icmp_data), .i_icmp_len(i_icmp_len),
    .i_icmp_last(i_icmp_last), .i_icmp_valid(i_icmp_valid), .i_pld_lock(i_pld_lock),
    .i_pld_rd_addr(i_pld_rd_addr), .o_pld_rd_data(nc_pld_rd_data), .o_trig_reply(nc_trig_reply),
    .o_trig_seq(nc_trig_seq), .o_trig_id(nc_trig_id), .o_pld_len(nc_pld_len),
    .o_err_csum(nc_err_csum), .o_err_len(nc_err_len), .o_drop(nc_drop)
  );

  always @(negedge i_clk) begin
    if (o_trig_reply)  n_rep++;
    if (o_drop)        n_drop++;
    if (o_err_len)     n_elen++;
    if (o_err_csum)    n_ecs++;
    if (nc_trig_reply) m_rep++;
    if (nc_err_csum)   m_ecs++;
  end

  // Ones-complement sum of the frame as big-endian 16-bit words, odd tail padded
  function automatic logic [15:0] frm_sum();
    int unsigned s = 0;
    logic [15:0] w;
    for (int i = 0; i < frm.size(); i += 2) begin
      w = {frm[i], (i + 1 < frm.size()) ? frm[i+1] : 8'h00};
      s += 32'(w);
    end
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return 16'(s);
  endfunction

  task automatic build(input logic [7:0] typ, input logic [15:0] id, input logic [15:0] seq,
                       input int n, input logic [7:0] base, input logic [15:0] delta);
    logic [15:0] c;
    frm.delete();
    frm.push_back(typ);      frm.push_back(8'h00);
    frm.push_back(8'h00);    frm.push_back(8'h00);
    frm.push_back(id[15:8]); frm.push_back(id[7:0]);
    frm.push_back(seq[15:8]); frm.push_back(seq[7:0]);
    for (int i = 0; i < n; i++) frm.push_back(base + 8'(i));
    c = ~frm_sum() + delta;
    frm[2] = c[15:8];
    frm[3] = c[7:0];
  endtask

  task automatic send(input int len_field, input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      i_icmp_valid = 1'b1;
      i_icmp_data  = frm[i];
      i_icmp_len   = 16'(len_field);
      i_icmp_last  = with_last && (i == n - 1);
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge i_clk);
      i_icmp_valid = 1'b0;
      i_icmp_last  = 1'b0;
      i_icmp_data  = 8'h00;
    end
  endtask

  task automatic rd(input int a, output logic [7:0] d);
    @(negedge i_clk);
    i_pld_rd_addr = AW'(a);
    @(negedge i_clk);
    d = o_pld_rd_data;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    idle(3);
    checks++; if (o_trig_reply !== 1'b0) begin errors++; $display("FAIL rst_reply got %b exp 0", o_trig_reply); end
    checks++; if (o_trig_seq !== 16'h0) begin errors++; $display("FAIL rst_seq got %h exp 0000", o_trig_seq); end
    checks++; if (o_trig_id !== 16'h0) begin errors++; $display("FAIL rst_id got %h exp 0000", o_trig_id); end
    checks++; if (o_pld_len !== 16'h0) begin errors++; $display("FAIL rst_len got %h exp 0000", o_pld_len); end
    checks++; if ({o_err_csum, o_err_len, o_drop} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {o_err_csum, o_err_len, o_drop}); end
    checks++; if (o_pld_rd_data !== 8'h00) begin errors++; $display("FAIL rst_rdata got %h exp 00", o_pld_rd_data); end
    @(negedge i_clk);
    i_rst = 1'b0;
    idle(2);
  endtask

  task automatic test_echo();
    int r0, e0;
    logic [7:0] d;
    r0 = n_rep; e0 = n_elen + n_ecs + n_drop;
    build(8'h08, 16'h1234, 16'h0007, 32, 8'h00, 16'h0);
    send(40, 40, 1'b1);
    idle(1);
    idle(1);
    checks++; if (o_trig_reply !== 1'b0) begin errors++; $display("FAIL echo_early got %b exp 0", o_trig_reply); end
    @(negedge i_clk);
    checks++; if (o_trig_reply !== 1'b1) begin errors++; $display("FAIL echo_lat got %b exp 1", o_trig_reply); end
    checks++; if (o_trig_seq !== 16'h0007) begin errors++; $display("FAIL echo_seq got %h exp 0007", o_trig_seq); end
    checks++; if (o_trig_id !== 16'h1234) begin errors++; $display("FAIL echo_id got %h exp 1234", o_trig_id); end
    checks++; if (o_pld_len !== 16'd32) begin errors++; $display("FAIL echo_len got %0d exp 32", o_pld_len); end
    idle(3);
    checks++; if (n_rep - r0 != 1) begin errors++; $display("FAIL echo_count got %0d exp 1", n_rep - r0); end
    checks++; if (n_elen + n_ecs + n_drop - e0 != 0) begin errors++; $display("FAIL echo_noerr got %0d exp 0", n_elen + n_ecs + n_drop - e0); end
    rd(5, d);
    checks++; if (d !== 8'h05) begin errors++; $display("FAIL echo_buf5 got %h exp 05", d); end
  endtask

  task automatic test_csum_err();
    int r0, c0, mr0, mc0;
    r0 = n_rep; c0 = n_ecs; mr0 = m_rep; mc0 = m_ecs;
    build(8'h08, 16'h1234, 16'h0009, 32, 8'h00, 16'h1);
    send(40, 40, 1'b1);
    idle(5);
    checks++; if (n_ecs - c0 != 1) begin errors++; $display("FAIL csum_err got %0d exp 1", n_ecs - c0); end
    checks++; if (n_rep - r0 != 0) begin errors++; $display("FAIL csum_noreply got %0d exp 0", n_rep - r0); end
    checks++; if (o_trig_seq !== 16'h0007) begin errors++; $display("FAIL csum_seqhold got %h exp 0007", o_trig_seq); end
    checks++; if (m_rep - mr0 != 1) begin errors++; $display("FAIL nocsum_reply got %0d exp 1", m_rep - mr0); end
    checks++; if (m_ecs - mc0 != 1) begin errors++; $display("FAIL nocsum_err got %0d exp 1", m_ecs - mc0); end
    checks++; if (nc_trig_seq !== 16'h0009) begin errors++; $display("FAIL nocsum_seq got %h exp 0009", nc_trig_seq); end
  endtask

  task automatic test_odd();
    int r0, e0;
    logic [7:0] d;
    r0 = n_rep; e0 = n_elen + n_ecs;
    build(8'h08, 16'h0ABC, 16'h0010, 33, 8'h00, 16'h0);
    send(41, 41, 1'b1);
    idle(5);
    checks++; if (n_rep - r0 != 1) begin errors++; $display("FAIL odd_reply got %0d exp 1", n_rep - r0); end
    checks++; if (n_elen + n_ecs - e0 != 0) begin errors++; $display("FAIL odd_noerr got %0d exp 0", n_elen + n_ecs - e0); end
    checks++; if (o_pld_len !== 16'd33) begin errors++; $display("FAIL odd_len got %0d exp 33", o_pld_len); end
    checks++; if (o_trig_id !== 16'h0ABC) begin errors++; $display("FAIL odd_id got %h exp 0abc", o_trig_id); end
    rd(32, d);
    checks++; if (d !== 8'h20) begin errors++; $display("FAIL odd_buf32 got %h exp 20", d); end
  endtask

  task automatic test_oversize();
    int r0, l0, c0;
    logic [7:0] d;
    r0 = n_rep; l0 = n_elen; c0 = n_ecs;
    build(8'h08, 16'h1234, 16'h0012, DEPTH + 1, 8'hA0, 16'h0);
    send(DEPTH + 9, DEPTH + 9, 1'b1);
    idle(5);
    checks++; if (n_elen - l0 != 1) begin errors++; $display("FAIL over_errlen got %0d exp 1", n_elen - l0); end
    checks++; if (n_rep - r0 != 0) begin errors++; $display("FAIL over_noreply got %0d exp 0", n_rep - r0); end
    checks++; if (n_ecs - c0 != 0) begin errors++; $display("FAIL over_nocsum got %0d exp 0", n_ecs - c0); end
    rd(0, d);
    checks++; if (d !== 8'hA0) begin errors++; $display("FAIL over_buf0 got %h exp a0", d); end
    rd(DEPTH - 1, d);
    checks++; if (d !== 8'hDF) begin errors++; $display("FAIL over_buflast got %h exp df", d); end
  endtask

  task automatic test_lock();
    int r0, dr0;
    logic [7:0] d;
    r0 = n_rep; dr0 = n_drop;
    i_pld_lock = 1'b1;
    build(8'h08, 16'h1234, 16'h0013, 16, 8'h40, 16'h0);
    send(24, 24, 1'b1);
    idle(5);
    i_pld_lock = 1'b0;
    checks++; if (n_drop - dr0 != 1) begin errors++; $display("FAIL lock_drop got %0d exp 1", n_drop - dr0); end
    checks++; if (n_rep - r0 != 0) begin errors++; $display("FAIL lock_noreply got %0d exp 0", n_rep - r0); end
    checks++; if (o_trig_seq !== 16'h0010) begin errors++; $display("FAIL lock_seqhold got %h exp 0010", o_trig_seq); end
    rd(0, d);
    checks++; if (d !== 8'hA0) begin errors++; $display("FAIL lock_buf0 got %h exp a0", d); end
  endtask

  task automatic test_type0();
    int r0, e0;
    r0 = n_rep; e0 = n_elen + n_ecs + n_drop;
    build(8'h00, 16'h1234, 16'h0014, 8, 8'h00, 16'h0);
    send(16, 16, 1'b1);
    idle(5);
    checks++; if (n_rep - r0 != 0) begin errors++; $display("FAIL type0_noreply got %0d exp 0", n_rep - r0); end
    checks++; if (n_elen + n_ecs + n_drop - e0 != 0) begin errors++; $display("FAIL type0_noerr got %0d exp 0", n_elen + n_ecs + n_drop - e0); end
  endtask

  task automatic test_trunc();
    int r0, l0;
    r0 = n_rep; l0 = n_elen;
    build(8'h08, 16'h1234, 16'h0015, 32, 8'h00, 16'h0);
    send(40, 5, 1'b0);
    idle(5);
    checks++; if (n_elen - l0 != 1) begin errors++; $display("FAIL trunc_errlen got %0d exp 1", n_elen - l0); end
    checks++; if (n_rep - r0 != 0) begin errors++; $display("FAIL trunc_noreply got %0d exp 0", n_rep - r0); end
  endtask

  task automatic test_back_to_back();
    int r0, e0;
    logic [7:0] d;
    r0 = n_rep; e0 = n_elen + n_ecs + n_drop;
    build(8'h08, 16'h5555, 16'h0021, 16, 8'h10, 16'h0);
    send(24, 24, 1'b1);
    build(8'h08, 16'h6666, 16'h0022, 20, 8'h80, 16'h0);
    send(28, 28, 1'b1);
    idle(5);
    checks++; if (n_rep - r0 != 2) begin errors++; $display("FAIL b2b_replies got %0d exp 2", n_rep - r0); end
    checks++; if (n_elen + n_ecs + n_drop - e0 != 0) begin errors++; $display("FAIL b2b_noerr got %0d exp 0", n_elen + n_ecs + n_drop - e0); end
    checks++; if (o_trig_seq !== 16'h0022) begin errors++; $display("FAIL b2b_seq got %h exp 0022", o_trig_seq); end
    checks++; if (o_pld_len !== 16'd20) begin errors++; $display("FAIL b2b_len got %0d exp 20", o_pld_len); end
    rd(0, d);
    checks++; if (d !== 8'h80) begin errors++; $display("FAIL b2b_buf0 got %h exp 80", d); end
  endtask

  task automatic test_reset_mid();
    int r0, l0;
    l0 = n_elen;
    build(8'h08, 16'h1234, 16'h0031, 32, 8'h00, 16'h0);
    send(40, 10, 1'b0);
    @(negedge i_clk);
    i_rst = 1'b1;
    i_icmp_valid = 1'b0;
    i_icmp_last = 1'b0;
    #1;
    checks++; if (o_trig_seq !== 16'h0) begin errors++; $display("FAIL rstmid_seq got %h exp 0000", o_trig_seq); end
    checks++; if (o_trig_id !== 16'h0) begin errors++; $display("FAIL rstmid_id got %h exp 0000", o_trig_id); end
    checks++; if (o_pld_len !== 16'h0) begin errors++; $display("FAIL rstmid_len got %h exp 0000", o_pld_len); end
    checks++; if ({o_trig_reply, o_err_csum, o_err_len, o_drop} !== 4'b0000) begin errors++; $display("FAIL rstmid_flags got %b exp 0000", {o_trig_reply, o_err_csum, o_err_len, o_drop}); end
    checks++; if (o_pld_rd_data !== 8'h00) begin errors++; $display("FAIL rstmid_rdata got %h exp 00", o_pld_rd_data); end
    idle(2);
    i_rst = 1'b0;
    idle(2);
    r0 = n_rep;
    build(8'h08, 16'h7777, 16'h0030, 12, 8'h00, 16'h0);
    send(20, 20, 1'b1);
    idle(5);
    checks++; if (n_elen - l0 != 0) begin errors++; $display("FAIL rstmid_noerrlen got %0d exp 0", n_elen - l0); end
    checks++; if (n_rep - r0 != 1) begin errors++; $display("FAIL rstmid_reply got %0d exp 1", n_rep - r0); end
    checks++; if (o_trig_seq !== 16'h0030) begin errors++; $display("FAIL rstmid_seq2 got %h exp 0030", o_trig_seq); end
  endtask

  initial begin
    i_rst         = 1'b1;
    i_icmp_data   = 8'h00;
    i_icmp_len    = 16'h0;
    i_icmp_last   = 1'b0;
    i_icmp_valid  = 1'b0;
    i_pld_lock    = 1'b0;
    i_pld_rd_addr = '0;
    test_reset();
    test_echo();
    test_csum_err();
    test_odd();
    test_oversize();
    test_lock();
    test_type0();
    test_trunc();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule
